// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM output path.
// Block, word and FIFO-entry definitions used by the serializer.
package gcm_pkg;

  localparam int GCM_BLK_BITS  = 128;
  localparam int WORD_BITS     = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef logic [GCM_BLK_BITS-1:0] gcm_blk_t;

  typedef struct packed {
    logic     last;
    gcm_blk_t blk;
  } gcm_out_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_e;

  function automatic logic [31:0] bswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/gcm_out_serializer_blk_fifo.sv
// Synchronous FIFO with combinational head read.
// Caller guarantees no push when full without pop, and no pop when empty.
module blk_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/gcm_out_serializer.sv
// Buffers 128-bit GCM blocks and drains them as 32-bit AXI-Stream words.
// Define GCM_OUT_BSWAP_EN to byte-reverse every output word.
module gcm_out_serializer
  import gcm_pkg::*;
#(
  parameter int GCM_BLK_BITS = 128,
  parameter int WORD_BITS    = 32,
  parameter int FIFO_DEPTH   = 4,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [GCM_BLK_BITS-1:0] gcm_out_blk,
  input  logic                    gcm_out_store_blk,
  input  logic                    gcm_done,
  output logic [WORD_BITS-1:0]    m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    out_fifo_full,
  output logic                    overflow,
  output logic                    proto_err
);

  gcm_out_entry_t wr_ent, head;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           push, pop, load;

  ser_state_e     state_q, state_d;
  gcm_blk_t       shreg_q, shreg_d;
  logic [1:0]     idx_q, idx_d;
  logic           last_q, last_d;
  logic           ovf_q, ovf_d;
  logic           perr_q, perr_d;
  logic [31:0]    word;

  assign wr_ent.last = gcm_done;
  assign wr_ent.blk  = gcm_out_blk;

  // A full FIFO still accepts a store if the serializer pops this cycle.
  assign push = gcm_out_store_blk &&
                ((fifo_count != CW'(FIFO_DEPTH)) || pop);

  blk_fifo #(
    .WIDTH ($bits(gcm_out_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: load = !fifo_empty;
      S_SEND: begin
        if (m_axis_tready) begin
          if (idx_q == 2'd3) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              idx_d   = 2'd0;
            end
          end else begin
            idx_d   = idx_q + 2'd1;
            shreg_d = shreg_q << WORD_BITS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_SEND;
      shreg_d = head.blk;
      last_d  = head.last;
      idx_d   = 2'd0;
    end
    pop    = load;
    ovf_d  = ovf_q || (gcm_out_store_blk && !push);
    perr_d = perr_q || (gcm_done && !gcm_out_store_blk);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  assign word = shreg_q[GCM_BLK_BITS-1 -: 32];

`ifdef GCM_OUT_BSWAP_EN
  assign m_axis_tdata = bswap32(word);
`else
  assign m_axis_tdata = word;
`endif

  assign m_axis_tvalid = (state_q == S_SEND);
  assign m_axis_tlast  = m_axis_tvalid && last_q && (idx_q == 2'd3);
  assign out_fifo_full = fifo_full;
  assign overflow      = ovf_q;
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_gcm_out_serializer.sv
// Directed bench for gcm_out_serializer: latency, throughput, backpressure,
// overflow, protocol error and mid-block reset.
module tb_gcm_out_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] blk = '0;
  logic         store = 1'b0;
  logic         done = 1'b0;
  logic [31:0]  tdata;
  logic         tvalid;
  logic         tready = 1'b0;
  logic         tlast;
  logic         full;
  logic         ovf;
  logic         perr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit toggle = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gcm_out_serializer dut (
    .clk               (clk),
    .reset             (reset),
    .gcm_out_blk       (blk),
    .gcm_out_store_blk (store),
    .gcm_done          (done),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid),
    .m_axis_tready     (tready),
    .m_axis_tlast      (tlast),
    .out_fifo_full     (full),
    .overflow          (ovf),
    .proto_err         (perr)
  );

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef GCM_OUT_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store_blk(input logic [127:0] b, input logic d);
    blk   = b;
    store = 1'b1;
    done  = d;
    @(negedge clk);
    store = 1'b0;
    done  = 1'b0;
  endtask

  task automatic recv_word(input logic [31:0] w, input logic lst,
                           input string tag, output int acc);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    acc = -1;
    while (!got) begin
      if (tvalid) begin
        chk({tag, "_data"}, tdata, exp_word(w));
        chk({tag, "_last"}, {31'b0, tlast}, {31'b0, lst});
        if (tready) begin
          acc = cyc;
          got = 1'b1;
        end
      end
      if (!got && n >= 50) begin
        checks++;
        failures++;
        $error("FAIL %s_timeout observed=no_word expected=word", tag);
        got = 1'b1;
      end
      @(negedge clk);
      n++;
      if (toggle) tready = ~tready;
    end
  endtask

  task automatic recv_block(input logic [127:0] b, input logic lst,
                            input string tag, output int a0, output int a3);
    int a;
    a0 = -1;
    a3 = -1;
    for (int i = 0; i < 4; i++) begin
      recv_word(b[127-32*i -: 32], lst && (i == 3),
                $sformatf("%s_w%0d", tag, i), a);
      if (i == 0) a0 = a;
      if (i == 3) a3 = a;
    end
  endtask

  localparam logic [127:0] B1 = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic [127:0] ab [3];
  logic [127:0] db [6];
  logic [127:0] eb [3];
  int k, a0, a3, f0, x0, x3;

  initial begin
    ab[0] = 128'h10101010_11111111_12121212_13131313;
    ab[1] = 128'h20202020_21212121_22222222_23232323;
    ab[2] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    for (int i = 0; i < 6; i++)
      db[i] = {4{8'(8'hA0 + i), 8'(i), 8'h5A, 8'(8'h10 * i)}};
    eb[0] = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
    eb[1] = 128'h11111111_22222222_33333333_44444444;
    eb[2] = 128'h55555555_66666666_77777777_88888888;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_tvalid", {31'b0, tvalid}, 32'h0);
    chk("rst_tlast", {31'b0, tlast}, 32'h0);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    chk("rst_perr", {31'b0, perr}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single block with gcm_done, latency 2
    tready = 1'b1;
    k = cyc;
    store_blk(B1, 1'b1);
    recv_block(B1, 1'b1, "single", a0, a3);
    chk("single_latency", a0 - k, 2);
    chk("single_span", a3 - a0, 3);
    chk("single_idle", {31'b0, tvalid}, 32'h0);

    // Three stores 4 cycles apart, no gaps
    fork
      begin
        store_blk(ab[0], 1'b0);
        repeat (3) @(negedge clk);
        store_blk(ab[1], 1'b0);
        repeat (3) @(negedge clk);
        store_blk(ab[2], 1'b1);
      end
      begin
        recv_block(ab[0], 1'b0, "b2b0", f0, a3);
        recv_block(ab[1], 1'b0, "b2b1", a0, a3);
        recv_block(ab[2], 1'b1, "b2b2", a0, a3);
      end
    join
    chk("b2b_span", a3 - f0, 11);
    chk("b2b_idle", {31'b0, tvalid}, 32'h0);

    // tready toggling every cycle
    tready = 1'b0;
    store_blk(ab[2], 1'b0);
    toggle = 1'b1;
    recv_block(ab[2], 1'b0, "tog", a0, a3);
    toggle = 1'b0;
    chk("tog_span", a3 - a0, 6);

    // Overflow: six stores into a stalled sink
    tready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) store_blk(db[i], 1'b0);
    chk("ovf_full", {31'b0, full}, 32'h1);
    chk("ovf_flag", {31'b0, ovf}, 32'h1);
    chk("ovf_tvalid", {31'b0, tvalid}, 32'h1);
    tready = 1'b1;
    for (int i = 0; i < 5; i++)
      recv_block(db[i], 1'b0, $sformatf("ovf%0d", i), a0, a3);
    chk("ovf_drained", {31'b0, tvalid}, 32'h0);
    chk("ovf_notfull", {31'b0, full}, 32'h0);
    chk("ovf_sticky", {31'b0, ovf}, 32'h1);

    // gcm_done without store
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("perr_set", {31'b0, perr}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("perr_novalid", {31'b0, tvalid}, 32'h0);
      chk("perr_nolast", {31'b0, tlast}, 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("perr_clr", {31'b0, perr}, 32'h0);
    chk("ovf_clr", {31'b0, ovf}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-block with two blocks queued
    tready = 1'b0;
    store_blk(eb[0], 1'b0);
    store_blk(eb[1], 1'b0);
    store_blk(eb[2], 1'b1);
    tready = 1'b1;
    recv_word(eb[0][127:96], 1'b0, "mid_w0", x0);
    recv_word(eb[0][95:64], 1'b0, "mid_w1", x3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_tvalid", {31'b0, tvalid}, 32'h0);
    chk("mid_tdata", tdata, 32'h0);
    chk("mid_full", {31'b0, full}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_empty", {31'b0, tvalid}, 32'h0);
    end
    store_blk(B1, 1'b1);
    recv_block(B1, 1'b1, "post", a0, a3);
    chk("post_idle", {31'b0, tvalid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcm_out_serializer.md
# gcm_out_serializer

Downstream stage of the `gcm` core. It captures each 128-bit block that `gcm` emits on its store strobe, which has no backpressure. It buffers the blocks in a small FIFO and drains them as 32-bit AXI-Stream words toward the DMA/output path. On the last word of the block stored together with `gcm_done` (the tag block), it asserts `tlast`.

## Interface
Parameters:
- `GCM_BLK_BITS`, 128, width of a GCM block; fixed at 128.
- `WORD_BITS`, 32, output stream word width; fixed at 32.
- `FIFO_DEPTH`, 4, number of blocks buffered; must be a power of 2, at least 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `gcm_out_blk`  in  128  block from `gcm`.
- `gcm_out_store_blk`  in  1  one-cycle strobe; capture `gcm_out_blk`.
- `gcm_done`  in  1  end of message; legal only coincident with `gcm_out_store_blk`.
- `m_axis_tdata`  out  32  output word.
- `m_axis_tvalid`  out  1  word valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last word of message.
- `out_fifo_full`  out  1  all `FIFO_DEPTH` entries occupied.
- `overflow`  out  1  sticky; a store was dropped.
- `proto_err`  out  1  sticky; `gcm_done` seen without `gcm_out_store_blk`.

## Operation
- FIFO entry: {last, blk[127:0]}.
  - `last` = `gcm_done` sampled with the store.
- Push occurs when `gcm_out_store_blk` is high, unless the FIFO is full and no pop happens that cycle.
  - A push and pop in the same cycle when full is accepted.
  - Otherwise the block is dropped and `overflow` is set.
- Serializer holds a 128-bit shift register, a 2-bit word index and a `busy` flag.
  - States: IDLE (`busy`=0) and SEND (`busy`=1).
  - IDLE to SEND: the FIFO is non-empty. Pop the head, load the shift register, set index 0.
  - In SEND, a word is accepted when `tvalid && tready`; then the index increments and the register shifts left 32.
  - On acceptance of index 3:
    - FIFO non-empty: pop and reload in the same cycle, staying in SEND with no bubble.
    - FIFO empty: go to IDLE.
- Word order: bits [127:96] first, [31:0] last.
- `m_axis_tvalid` = `busy`.
- `m_axis_tlast` = `busy && last && index==3`.
- `m_axis_tdata` is stable while `tvalid && !tready`.
- `gcm_done` with no store that cycle: ignored; `proto_err` set.
- `overflow` and `proto_err` clear only on reset.
- Reset, including mid-block:
  - FIFO pointers and count are cleared, so buffered and in-flight words are discarded.
  - `busy`=0 and index=0.
  - All outputs are 0: `tdata`, `tvalid`, `tlast`, `out_fifo_full`, `overflow`, `proto_err`.

## Timing
- A store sampled at edge N sets FIFO count at N.
- IDLE pops at edge N+1, so first `tvalid` is high after edge N+1. Store-to-first-word latency is 2 cycles.
- Throughput with `tready`=1: one word per cycle, one block per 4 cycles, sustained indefinitely.
- `gcm` may produce at most one block per 4 cycles for lossless operation with an always-ready sink. Bursts are absorbed up to `FIFO_DEPTH`.
- `out_fifo_full` is registered and reflects count after the current edge. Upstream may use it to deassert `gcm_valid`.
- Count width is clog2(`FIFO_DEPTH`)+1 bits. Pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `GCM_OUT_BSWAP_EN` defined:
  - each output word is byte-reversed (`tdata[7:0]` = word[31:24], and so on).
  - word order and `tlast` are unchanged.
- Undefined: words pass through unmodified (big-endian, AES byte order).

## Structure
- Shared package `gcm_pkg` holds:
  - `GCM_BLK_BITS`, `WORD_BITS`, `WORDS_PER_BLK`=4.
  - typedef `gcm_blk_t` (logic [127:0]).
  - typedef `gcm_out_entry_t` (struct {last, blk}).
- One sub-module, `blk_fifo`: synchronous FIFO parameterised on width and depth, with push/pop/full/empty/count.
  - The serializer FSM lives in the top.

## Test plan
- Single block 0x00112233_44556677_8899aabb_ccddeeff stored with `gcm_done`, `tready`=1 → words 00112233, 44556677, 8899aabb, ccddeeff on cycles N+2..N+5; `tlast` only on ccddeeff.
- Three stores 4 cycles apart, last with `gcm_done`, `tready`=1 → 12 consecutive words, no `tvalid` gaps, `tlast` only on word 12.
- `tready` toggled 0/1 every cycle during a block → each word held stable until accepted, order preserved, 8 cycles per block.
- `tready`=0, 6 consecutive stores with `FIFO_DEPTH`=4 → first popped into the serializer, next 4 buffered, 6th dropped; `out_fifo_full`=1, `overflow`=1; after release exactly 5 blocks emerge.
- `gcm_done` pulse alone → `proto_err`=1, no words emitted, no `tlast`. Reset then clears it.
- Reset asserted after word 2 of a block with 2 blocks queued → `tvalid`=0 next cycle, FIFO empty, a subsequent store is emitted from word 0. With `GCM_OUT_BSWAP_EN`, a block starting 0x00112233 emits 33221100.
